// File: rtl/rob_multi_cdb.sv
// Reorder buffer with NUM_CDB result buses, in-order single commit, store handshake and mispredict flush.
// Optional feature: define ROB_CDB_BYPASS_EN to forward same-cycle CDB results to the lookup ports.
module rob_multi_cdb #(
    parameter int DEPTH   = 16,
    parameter int TAG_W   = 4,
    parameter int NUM_CDB = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_rdy,
    input  logic                      i_alloc_valid,
    input  logic [1:0]                i_alloc_kind,
    input  logic [4:0]                i_alloc_rd,
    input  logic [DATA_W-1:0]         i_alloc_pc,
    input  logic                      i_alloc_pred,
    input  logic [1:0]                i_alloc_size,
    output logic [TAG_W-1:0]          o_alloc_tag,
    output logic                      o_alloc_ready,
    input  logic [NUM_CDB-1:0]        i_cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]  i_cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0] i_cdb_value,
    input  logic [NUM_CDB*DATA_W-1:0] i_cdb_aux,
    input  logic [TAG_W-1:0]          i_rd_tag1,
    input  logic [TAG_W-1:0]          i_rd_tag2,
    output logic [DATA_W-1:0]         o_rd_value1,
    output logic [DATA_W-1:0]         o_rd_value2,
    output logic                      o_rd_ready1,
    output logic                      o_rd_ready2,
    output logic                      o_cm_reg_en,
    output logic [4:0]                o_cm_reg_idx,
    output logic [TAG_W-1:0]          o_cm_reg_tag,
    output logic [DATA_W-1:0]         o_cm_reg_value,
    output logic                      o_mem_req,
    output logic [DATA_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_data,
    output logic [1:0]                o_mem_size,
    input  logic                      i_mem_ack,
    output logic                      o_bp_upd_en,
    output logic [DATA_W-1:0]         o_bp_pc,
    output logic                      o_bp_taken,
    output logic                      o_flush,
    output logic [DATA_W-1:0]         o_flush_pc,
    output logic [TAG_W-1:0]          o_count
);
    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_MEM = 2'd1;
    localparam logic [1:0] S_FLUSH    = 2'd2;

    localparam logic [1:0] K_ALU    = 2'd0;
    localparam logic [1:0] K_BRANCH = 2'd1;
    localparam logic [1:0] K_STORE  = 2'd2;
    localparam logic [1:0] K_JALR   = 2'd3;

    localparam logic [TAG_W-1:0] LAST_SLOT = TAG_W'(DEPTH - 1);
    localparam logic [TAG_W-1:0] FIRST_SLOT = TAG_W'(1);

    logic              r_busy  [DEPTH];
    logic              r_ready [DEPTH];
    logic [1:0]        r_kind  [DEPTH];
    logic [4:0]        r_rd    [DEPTH];
    logic [DATA_W-1:0] r_pc    [DEPTH];
    logic              r_pred  [DEPTH];
    logic [1:0]        r_size  [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];
    logic [DATA_W-1:0] r_aux   [DEPTH];

    // r_tail is the slot the next allocation takes, r_head the oldest live slot
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W-1:0]  r_count;
    logic [1:0]        r_state;

    logic              r_cm_reg_en;
    logic [4:0]        r_cm_reg_idx;
    logic [TAG_W-1:0]  r_cm_reg_tag;
    logic [DATA_W-1:0] r_cm_reg_value;
    logic              r_mem_req;
    logic [DATA_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic [1:0]        r_mem_size;
    logic              r_bp_upd_en;
    logic [DATA_W-1:0] r_bp_pc;
    logic              r_bp_taken;
    logic              r_flush;
    logic [DATA_W-1:0] r_flush_pc;

    logic [TAG_W-1:0]  w_cdb_tag   [NUM_CDB];
    logic [DATA_W-1:0] w_cdb_value [NUM_CDB];
    logic [DATA_W-1:0] w_cdb_aux   [NUM_CDB];
    logic              w_cdb_wr    [NUM_CDB];

    logic [TAG_W-1:0]  w_lk_tag [2];
    logic [DATA_W-1:0] w_lk_val [2];
    logic              w_lk_rdy [2];

    logic              w_alloc;
    logic              w_head_rdy;
    logic              w_retire;
    logic [1:0]        w_h_kind;
    logic              w_h_taken;
    logic              w_h_mispred;

    function automatic logic [TAG_W-1:0] f_next(input logic [TAG_W-1:0] p);
        return (p == LAST_SLOT) ? FIRST_SLOT : p + TAG_W'(1);
    endfunction

    always_comb begin
        for (int b = 0; b < NUM_CDB; b++) begin
            w_cdb_tag[b]   = i_cdb_tag[b*TAG_W +: TAG_W];
            w_cdb_value[b] = i_cdb_value[b*DATA_W +: DATA_W];
            w_cdb_aux[b]   = i_cdb_aux[b*DATA_W +: DATA_W];
            w_cdb_wr[b]    = i_cdb_valid[b] && (w_cdb_tag[b] != '0) && r_busy[w_cdb_tag[b]];
        end
    end

    assign w_lk_tag[0] = i_rd_tag1;
    assign w_lk_tag[1] = i_rd_tag2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_lk_val[p] = r_value[w_lk_tag[p]];
            w_lk_rdy[p] = r_ready[w_lk_tag[p]];
`ifdef ROB_CDB_BYPASS_EN
            for (int b = 0; b < NUM_CDB; b++) begin
                if (w_cdb_wr[b] && (w_cdb_tag[b] == w_lk_tag[p])) begin
                    w_lk_val[p] = w_cdb_value[b];
                    w_lk_rdy[p] = 1'b1;
                end
            end
`endif
            if (w_lk_tag[p] == '0) begin
                w_lk_val[p] = '0;
                w_lk_rdy[p] = 1'b1;
            end
        end
    end

    assign o_rd_value1 = w_lk_val[0];
    assign o_rd_value2 = w_lk_val[1];
    assign o_rd_ready1 = w_lk_rdy[0];
    assign o_rd_ready2 = w_lk_rdy[1];

    assign o_alloc_ready = (r_count < LAST_SLOT) && (r_state != S_FLUSH);
    assign o_alloc_tag   = o_alloc_ready ? r_tail : '0;
    assign w_alloc       = i_alloc_valid && o_alloc_ready;

    assign w_head_rdy  = (r_count != '0) && r_ready[r_head];
    assign w_h_kind    = r_kind[r_head];
    assign w_h_taken   = r_value[r_head][0];
    assign w_h_mispred = w_h_taken != r_pred[r_head];
    // Stores retire on the ack, not when they leave IDLE
    assign w_retire    = ((r_state == S_IDLE) && w_head_rdy && (w_h_kind != K_STORE)) ||
                         ((r_state == S_WAIT_MEM) && i_mem_ack);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_busy[i]  <= 1'b0;
                r_ready[i] <= 1'b0;
                r_kind[i]  <= '0;
                r_rd[i]    <= '0;
                r_pc[i]    <= '0;
                r_pred[i]  <= 1'b0;
                r_size[i]  <= '0;
                r_value[i] <= '0;
                r_aux[i]   <= '0;
            end
            r_head         <= FIRST_SLOT;
            r_tail         <= FIRST_SLOT;
            r_count        <= '0;
            r_state        <= S_IDLE;
            r_cm_reg_en    <= 1'b0;
            r_cm_reg_idx   <= '0;
            r_cm_reg_tag   <= '0;
            r_cm_reg_value <= '0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_data     <= '0;
            r_mem_size     <= '0;
            r_bp_upd_en    <= 1'b0;
            r_bp_pc        <= '0;
            r_bp_taken     <= 1'b0;
            r_flush        <= 1'b0;
            r_flush_pc     <= '0;
        end else if (i_rdy) begin
            r_cm_reg_en <= 1'b0;
            r_bp_upd_en <= 1'b0;
            if (r_state == S_FLUSH) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_busy[i]  <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
                r_head  <= FIRST_SLOT;
                r_tail  <= FIRST_SLOT;
                r_count <= '0;
                r_flush <= 1'b0;
                r_state <= S_IDLE;
            end else begin
                // Ascending bus order lets the highest bus index win a tag collision
                for (int b = 0; b < NUM_CDB; b++) begin
                    if (w_cdb_wr[b]) begin
                        r_value[w_cdb_tag[b]] <= w_cdb_value[b];
                        r_aux[w_cdb_tag[b]]   <= w_cdb_aux[b];
                        r_ready[w_cdb_tag[b]] <= 1'b1;
                    end
                end
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_ready[r_tail] <= 1'b0;
                    r_kind[r_tail]  <= i_alloc_kind;
                    r_rd[r_tail]    <= i_alloc_rd;
                    r_pc[r_tail]    <= i_alloc_pc;
                    r_pred[r_tail]  <= i_alloc_pred;
                    r_size[r_tail]  <= i_alloc_size;
                    r_tail          <= f_next(r_tail);
                end
                if (w_retire) begin
                    r_busy[r_head]  <= 1'b0;
                    r_ready[r_head] <= 1'b0;
                    r_head          <= f_next(r_head);
                end
                if (w_alloc && !w_retire) begin
                    r_count <= r_count + TAG_W'(1);
                end else if (!w_alloc && w_retire) begin
                    r_count <= r_count - TAG_W'(1);
                end

                if ((r_state == S_IDLE) && w_head_rdy) begin
                    case (w_h_kind)
                        K_ALU, K_JALR: begin
                            r_cm_reg_en    <= (r_rd[r_head] != 5'd0);
                            r_cm_reg_idx   <= r_rd[r_head];
                            r_cm_reg_tag   <= r_head;
                            r_cm_reg_value <= r_value[r_head];
                            if (w_h_kind == K_JALR) begin
                                r_flush    <= 1'b1;
                                r_flush_pc <= r_aux[r_head];
                                r_state    <= S_FLUSH;
                            end
                        end
                        K_BRANCH: begin
                            r_bp_upd_en <= 1'b1;
                            r_bp_pc     <= r_pc[r_head];
                            r_bp_taken  <= w_h_taken;
                            if (w_h_mispred) begin
                                r_flush    <= 1'b1;
                                r_flush_pc <= w_h_taken ? r_aux[r_head] : r_pc[r_head] + DATA_W'(4);
                                r_state    <= S_FLUSH;
                            end
                        end
                        default: begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_aux[r_head];
                            r_mem_data <= r_value[r_head];
                            r_mem_size <= r_size[r_head];
                            r_state    <= S_WAIT_MEM;
                        end
                    endcase
                end else if ((r_state == S_WAIT_MEM) && i_mem_ack) begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            end
        end
    end

    assign o_cm_reg_en    = r_cm_reg_en;
    assign o_cm_reg_idx   = r_cm_reg_idx;
    assign o_cm_reg_tag   = r_cm_reg_tag;
    assign o_cm_reg_value = r_cm_reg_value;
    assign o_mem_req      = r_mem_req;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_data     = r_mem_data;
    assign o_mem_size     = r_mem_size;
    assign o_bp_upd_en    = r_bp_upd_en;
    assign o_bp_pc        = r_bp_pc;
    assign o_bp_taken     = r_bp_taken;
    assign o_flush        = r_flush;
    assign o_flush_pc     = r_flush_pc;
    assign o_count        = r_count;

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed bench for rob_multi_cdb: vector tables for alloc/CDB/lookup plus sequences for commit, store, flush and wrap.
module tb_rob_multi_cdb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [1:0]  alloc_kind = '0;
    logic [4:0]  alloc_rd = '0;
    logic [31:0] alloc_pc = '0;
    logic        alloc_pred = 1'b0;
    logic [1:0]  alloc_size = '0;
    logic [3:0]  alloc_tag;
    logic        alloc_ready;
    logic        cv [2];
    logic [3:0]  ct [2];
    logic [31:0] cd [2];
    logic [31:0] ca [2];
    logic [3:0]  rd_tag1 = '0, rd_tag2 = '0;
    logic [31:0] rd_value1, rd_value2;
    logic        rd_ready1, rd_ready2;
    logic        cm_reg_en;
    logic [4:0]  cm_reg_idx;
    logic [3:0]  cm_reg_tag;
    logic [31:0] cm_reg_value;
    logic        mem_req;
    logic [31:0] mem_addr, mem_data;
    logic [1:0]  mem_size;
    logic        mem_ack = 1'b0;
    logic        bp_upd_en, bp_taken, flush;
    logic [31:0] bp_pc, flush_pc;
    logic [3:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rob_multi_cdb dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rdy(rdy),
        .i_alloc_valid(alloc_valid), .i_alloc_kind(alloc_kind), .i_alloc_rd(alloc_rd),
        .i_alloc_pc(alloc_pc), .i_alloc_pred(alloc_pred), .i_alloc_size(alloc_size),
        .o_alloc_tag(alloc_tag), .o_alloc_ready(alloc_ready),
        .i_cdb_valid({cv[1], cv[0]}), .i_cdb_tag({ct[1], ct[0]}),
        .i_cdb_value({cd[1], cd[0]}), .i_cdb_aux({ca[1], ca[0]}),
        .i_rd_tag1(rd_tag1), .i_rd_tag2(rd_tag2),
        .o_rd_value1(rd_value1), .o_rd_value2(rd_value2),
        .o_rd_ready1(rd_ready1), .o_rd_ready2(rd_ready2),
        .o_cm_reg_en(cm_reg_en), .o_cm_reg_idx(cm_reg_idx), .o_cm_reg_tag(cm_reg_tag),
        .o_cm_reg_value(cm_reg_value),
        .o_mem_req(mem_req), .o_mem_addr(mem_addr), .o_mem_data(mem_data), .o_mem_size(mem_size),
        .i_mem_ack(mem_ack),
        .o_bp_upd_en(bp_upd_en), .o_bp_pc(bp_pc), .o_bp_taken(bp_taken),
        .o_flush(flush), .o_flush_pc(flush_pc), .o_count(count)
    );

    typedef struct {
        logic       vld;
        logic [3:0] exp_tag;
        logic       exp_rdy;
        logic [3:0] exp_cnt;
    } alloc_vec_t;

    typedef struct {
        logic        v0;
        logic [3:0]  t0;
        logic [31:0] d0;
        logic        v1;
        logic [3:0]  t1;
        logic [31:0] d1;
        logic [3:0]  lk;
        logic        exp_rdy;
        logic [31:0] exp_val;
    } cdb_vec_t;

    alloc_vec_t atv [17];
    cdb_vec_t   ctv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cdb_off();
        for (int b = 0; b < 2; b++) begin
            cv[b] = 1'b0; ct[b] = '0; cd[b] = '0; ca[b] = '0;
        end
    endtask

    task automatic cdb(input int b, input logic [3:0] t, input logic [31:0] d, input logic [31:0] a);
        cv[b] = 1'b1; ct[b] = t; cd[b] = d; ca[b] = a;
    endtask

    task automatic alloc(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pred, input logic [1:0] sz);
        alloc_valid = 1'b1; alloc_kind = k; alloc_rd = rd; alloc_pc = pc;
        alloc_pred = pred; alloc_size = sz;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alloc_valid = 1'b0; mem_ack = 1'b0; rdy = 1'b1;
        cdb_off();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 15; i++) atv[i] = '{1'b1, 4'(i + 1), 1'b1, 4'(i)};
        atv[15] = '{1'b1, 4'd0, 1'b0, 4'd15};
        atv[16] = '{1'b0, 4'd0, 1'b0, 4'd15};

        ctv[0] = '{1'b1, 4'd2, 32'd7,     1'b0, 4'd0, 32'd0,     4'd2, 1'b1, 32'd7};
        ctv[1] = '{1'b0, 4'd0, 32'd0,     1'b1, 4'd5, 32'd5,     4'd5, 1'b1, 32'd5};
        ctv[2] = '{1'b1, 4'd3, 32'h11,    1'b1, 4'd3, 32'h22,    4'd3, 1'b1, 32'h22};
        ctv[3] = '{1'b1, 4'd0, 32'h99,    1'b0, 4'd0, 32'd0,     4'd0, 1'b1, 32'd0};
        ctv[4] = '{1'b0, 4'd0, 32'd0,     1'b0, 4'd0, 32'd0,     4'd4, 1'b0, 32'd0};
        ctv[5] = '{1'b1, 4'd4, 32'h33,    1'b1, 4'd6, 32'h44,    4'd4, 1'b1, 32'h33};
        ctv[6] = '{1'b0, 4'd0, 32'd0,     1'b0, 4'd0, 32'd0,     4'd6, 1'b1, 32'h44};
        ctv[7] = '{1'b1, 4'd2, 32'h55,    1'b0, 4'd0, 32'd0,     4'd2, 1'b1, 32'h55};

        cdb_off();
        do_reset();
        chk("reset_alloc_tag", 32'(alloc_tag), 32'd1);
        chk("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_flush", 32'(flush), 32'd0);
        chk("reset_cm_reg_en", 32'(cm_reg_en), 32'd0);
        chk("reset_tag0_ready", 32'(rd_ready1), 32'd1);
        chk("reset_tag0_value", rd_value1, 32'd0);

        // rdy low holds state even with a request present
        rdy = 1'b0; alloc_valid = 1'b1;
        step();
        chk("rdy_hold_count", 32'(count), 32'd0);
        chk("rdy_hold_tag", 32'(alloc_tag), 32'd1);
        rdy = 1'b1; alloc_valid = 1'b0;

        for (int i = 0; i < 17; i++) begin
            chk($sformatf("fill%0d_tag", i), 32'(alloc_tag), 32'(atv[i].exp_tag));
            chk($sformatf("fill%0d_ready", i), 32'(alloc_ready), 32'(atv[i].exp_rdy));
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(atv[i].exp_cnt));
            alloc_valid = atv[i].vld; alloc_kind = 2'd0; alloc_rd = 5'(i + 1);
            step();
        end
        alloc_valid = 1'b0;

        // head (tag 1) never gets a result, so nothing commits during this table
        for (int i = 0; i < 8; i++) begin
            cv[0] = ctv[i].v0; ct[0] = ctv[i].t0; cd[0] = ctv[i].d0; ca[0] = '0;
            cv[1] = ctv[i].v1; ct[1] = ctv[i].t1; cd[1] = ctv[i].d1; ca[1] = '0;
            rd_tag1 = ctv[i].lk; rd_tag2 = ctv[i].lk;
            step();
            chk($sformatf("cdb%0d_ready1", i), 32'(rd_ready1), 32'(ctv[i].exp_rdy));
            chk($sformatf("cdb%0d_value1", i), rd_value1, ctv[i].exp_val);
            chk($sformatf("cdb%0d_ready2", i), 32'(rd_ready2), 32'(ctv[i].exp_rdy));
            chk($sformatf("cdb%0d_value2", i), rd_value2, ctv[i].exp_val);
            cdb_off();
        end
        chk("cdb_no_commit", 32'(cm_reg_en), 32'd0);
        chk("cdb_count", 32'(count), 32'd15);

        // Out-of-order results, in-order commit; result for a free slot is dropped
        do_reset();
        rd_tag1 = 4'd3;
        cdb(0, 4'd3, 32'h77, 32'd0);
        step();
        cdb_off();
        chk("drop_free_ready", 32'(rd_ready1), 32'd0);
        chk("drop_free_count", 32'(count), 32'd0);
        alloc(2'd0, 5'd1, 32'h0, 1'b0, 2'd0);
        alloc(2'd0, 5'd2, 32'h4, 1'b0, 2'd0);
        cdb(0, 4'd2, 32'd7, 32'd0);
        step();
        cdb_off();
        chk("order_wait_head", 32'(cm_reg_en), 32'd0);
        cdb(1, 4'd1, 32'd5, 32'd0);
        step();
        cdb_off();
        chk("order_not_yet", 32'(cm_reg_en), 32'd0);
        step();
        chk("order_c1_en", 32'(cm_reg_en), 32'd1);
        chk("order_c1_idx", 32'(cm_reg_idx), 32'd1);
        chk("order_c1_val", cm_reg_value, 32'd5);
        chk("order_c1_tag", 32'(cm_reg_tag), 32'd1);
        step();
        chk("order_c2_en", 32'(cm_reg_en), 32'd1);
        chk("order_c2_idx", 32'(cm_reg_idx), 32'd2);
        chk("order_c2_val", cm_reg_value, 32'd7);
        step();
        chk("order_idle_en", 32'(cm_reg_en), 32'd0);
        chk("order_count", 32'(count), 32'd0);

        // Store: mem_req held three cycles until the ack
        do_reset();
        alloc(2'd2, 5'd0, 32'h10, 1'b0, 2'd0);
        cdb(0, 4'd1, 32'hAB, 32'h100);
        step();
        cdb_off();
        step();
        chk("st_req1", 32'(mem_req), 32'd1);
        chk("st_addr", mem_addr, 32'h100);
        chk("st_data", mem_data, 32'hAB);
        chk("st_size", 32'(mem_size), 32'd0);
        chk("st_cm_en", 32'(cm_reg_en), 32'd0);
        step();
        chk("st_req2", 32'(mem_req), 32'd1);
        chk("st_count_wait", 32'(count), 32'd1);
        step();
        chk("st_req3", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("st_req_drop", 32'(mem_req), 32'd0);
        chk("st_count_done", 32'(count), 32'd0);

        // Mispredicted branch flushes younger work
        do_reset();
        alloc(2'd1, 5'd0, 32'h40, 1'b0, 2'd0);
        alloc(2'd0, 5'd3, 32'h44, 1'b0, 2'd0);
        cdb(0, 4'd1, 32'd1, 32'h80);
        step();
        cdb_off();
        step();
        chk("br_upd", 32'(bp_upd_en), 32'd1);
        chk("br_pc", bp_pc, 32'h40);
        chk("br_taken", 32'(bp_taken), 32'd1);
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_flush_pc", flush_pc, 32'h80);
        chk("br_ready_in_flush", 32'(alloc_ready), 32'd0);
        chk("br_count_pre", 32'(count), 32'd1);
        step();
        chk("br_flush_end", 32'(flush), 32'd0);
        chk("br_count_post", 32'(count), 32'd0);
        chk("br_tag_post", 32'(alloc_tag), 32'd1);
        chk("br_upd_pulse", 32'(bp_upd_en), 32'd0);

        // Correctly predicted branch, then JALR
        alloc(2'd1, 5'd0, 32'h60, 1'b1, 2'd0);
        alloc(2'd3, 5'd5, 32'h64, 1'b0, 2'd0);
        cdb(0, 4'd1, 32'd1, 32'h90);
        cdb(1, 4'd2, 32'h44, 32'h200);
        step();
        cdb_off();
        step();
        chk("brok_upd", 32'(bp_upd_en), 32'd1);
        chk("brok_pc", bp_pc, 32'h60);
        chk("brok_flush", 32'(flush), 32'd0);
        step();
        chk("jalr_en", 32'(cm_reg_en), 32'd1);
        chk("jalr_idx", 32'(cm_reg_idx), 32'd5);
        chk("jalr_val", cm_reg_value, 32'h44);
        chk("jalr_flush", 32'(flush), 32'd1);
        chk("jalr_flush_pc", flush_pc, 32'h200);
        step();
        chk("jalr_flush_end", 32'(flush), 32'd0);
        chk("jalr_count", 32'(count), 32'd0);

        // Wrap: tags run 1..15 then back to 1, never 0
        do_reset();
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("wrap%0d_tag", i), 32'(alloc_tag), 32'((i % 15) + 1));
            alloc(2'd0, 5'd7, 32'(i * 4), 1'b0, 2'd0);
            cdb(0, 4'((i % 15) + 1), 32'(i + 100), 32'd0);
            step();
            cdb_off();
            step();
            chk($sformatf("wrap%0d_cm_tag", i), 32'(cm_reg_tag), 32'((i % 15) + 1));
            chk($sformatf("wrap%0d_cm_val", i), cm_reg_value, 32'(i + 100));
        end
        chk("wrap_count", 32'(count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
